// File: rtl/input_encoder_if.sv
// Command bus between the input encoder and the game loop: raw keys and pause
// switch in, debounced levels and one-cycle move commands out.
interface input_encoder_if;
  logic [1:0] button_raw;   // active-low keys: bit0 = down, bit1 = up
  logic       switch_raw;   // pause slide switch, active-high
  logic       move_valid;   // one-cycle command strobe
  logic [1:0] move_cmd;     // 01 down, 10 up, 11 fire
  logic       pause;        // debounced pause level
  logic [1:0] held;         // debounced pressed state, active-high

  // Encoder side
  modport master (
    input  button_raw,
    input  switch_raw,
    output move_valid,
    output move_cmd,
    output pause,
    output held
  );

  // Stimulus / consumer side
  modport slave (
    output button_raw,
    output switch_raw,
    input  move_valid,
    input  move_cmd,
    input  pause,
    input  held
  );
endinterface

// File: rtl/input_encoder.sv
// Input encoder: synchronizes and debounces two push keys and a pause switch,
// then turns key activity into move commands (single press, auto-repeat and a
// two-key "fire" chord). Commands are suppressed while paused and until every
// key has been released after a pause.
module input_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input_encoder_if.master bus
);

  // One counter width serves debounce and repeat timing; it covers the
  // largest terminal count so no counter can wrap.
  localparam int MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_ALL = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  // Terminal values: the event fires on the edge where the count would reach
  // the parameter, so compare against parameter-1.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Idle ("released") level per channel: keys are active-low, switch active-high.
  // Channel order: 0 = down key, 1 = up key, 2 = pause switch.
  localparam logic [2:0] REST_LEVEL = 3'b011;

  // Command FSM states
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_HOLD     = 3'd1;
  localparam logic [2:0] ST_REPEAT   = 3'd2;
  localparam logic [2:0] ST_CHORD    = 3'd3;
  localparam logic [2:0] ST_WAIT_REL = 3'd4;

  localparam logic [1:0] CMD_FIRE = 2'b11;

  logic [2:0] raw_in;
  logic [2:0] stable_lvl;
  logic [1:0] held;
  logic       pause;

  assign raw_in = {bus.switch_raw, bus.button_raw};

  // ---------------------------------------------------------------------------
  // Per-channel two-flop synchronizer followed by a debounce counter. The
  // counter runs while the synchronized level disagrees with the accepted
  // level and restarts on any agreement, so only an uninterrupted run of
  // DEBOUNCE_CYCLES disagreeing samples flips the accepted level.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] db_cnt_q;
    logic [CNT_W-1:0] db_cnt_d;

    // Debounce next-state: count disagreement, accept on the terminal edge
    always_comb begin
      db_cnt_d = '0;
      stable_d = stable_q;
      if (sync2_q != stable_q) begin
        if (db_cnt_q == DB_LAST) begin
          stable_d = sync2_q;
        end else begin
          db_cnt_d = db_cnt_q + CNT_ONE;
        end
      end
    end

    // Synchronizer and debounce registers; reset to the released level
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q  <= REST_LEVEL[gi];
        sync2_q  <= REST_LEVEL[gi];
        stable_q <= REST_LEVEL[gi];
        db_cnt_q <= '0;
      end else begin
        sync1_q  <= raw_in[gi];
        sync2_q  <= sync1_q;
        stable_q <= stable_d;
        db_cnt_q <= db_cnt_d;
      end
    end

    assign stable_lvl[gi] = stable_q;
  end

  assign held  = ~stable_lvl[1:0];
  assign pause = stable_lvl[2];

  // ---------------------------------------------------------------------------
  // Command FSM
  // ---------------------------------------------------------------------------
  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic             key_q;          // key owning HOLD/REPEAT: 0 = down, 1 = up
  logic             key_d;
  logic [CNT_W-1:0] rep_cnt_q;
  logic [CNT_W-1:0] rep_cnt_d;
  logic             move_valid_q;
  logic             move_valid_d;
  logic [1:0]       move_cmd_q;
  logic [1:0]       move_cmd_d;
  logic [1:0]       key_code;

  assign key_code = key_q ? 2'b10 : 2'b01;

  // FSM next-state and command generation
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    rep_cnt_d    = rep_cnt_q;
    move_valid_d = 1'b0;
    move_cmd_d   = move_cmd_q;

    if (pause) begin
      // Pause overrides everything, including a pulse due this cycle.
      state_d   = ST_WAIT_REL;
      rep_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // held is 00 on entry to IDLE, so any set bit is a fresh press.
          if (held == 2'b11) begin
            move_valid_d = 1'b1;
            move_cmd_d   = CMD_FIRE;
            state_d      = ST_CHORD;
          end else if (held != 2'b00) begin
            move_valid_d = 1'b1;
            move_cmd_d   = held;
            key_d        = held[1];
            rep_cnt_d    = '0;
            state_d      = ST_HOLD;
          end
        end

        ST_HOLD, ST_REPEAT: begin
          if (held == 2'b11) begin
            move_valid_d = 1'b1;
            move_cmd_d   = CMD_FIRE;
            state_d      = ST_CHORD;
          end else if (!held[key_q]) begin
            state_d = ST_IDLE;
          end else if (rep_cnt_q == ((state_q == ST_HOLD) ? RD_LAST : RR_LAST)) begin
            move_valid_d = 1'b1;
            move_cmd_d   = key_code;
            rep_cnt_d    = '0;
            state_d      = ST_REPEAT;
          end else begin
            rep_cnt_d = rep_cnt_q + CNT_ONE;
          end
        end

        ST_CHORD, ST_WAIT_REL: begin
          // Silent until every key is up; pause is already known to be 0 here.
          if (held == 2'b00) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // The strobe may never be high on two consecutive cycles: a command that
      // lands right after another is postponed by freezing the FSM for a cycle,
      // so it is re-evaluated (and normally issued) on the next edge.
      if (move_valid_d && move_valid_q) begin
        state_d      = state_q;
        key_d        = key_q;
        rep_cnt_d    = rep_cnt_q;
        move_valid_d = 1'b0;
        move_cmd_d   = move_cmd_q;
      end
    end
  end

  // FSM and registered command outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      key_q        <= 1'b0;
      rep_cnt_q    <= '0;
      move_valid_q <= 1'b0;
      move_cmd_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      rep_cnt_q    <= rep_cnt_d;
      move_valid_q <= move_valid_d;
      move_cmd_q   <= move_cmd_d;
    end
  end

  assign bus.move_valid = move_valid_q;
  assign bus.move_cmd   = move_cmd_q;
  assign bus.pause      = pause;
  assign bus.held       = held;

endmodule

// File: tb/tb_input_encoder.sv
// Bench for input_encoder: a behavioural model (delay line + sliding-window
// debounce + press-age command rules) is checked against the DUT every cycle,
// and directed scenarios pin the model's pulse timing with literal values.
module tb_input_encoder;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 5;
  localparam logic [2:0] REST = 3'b011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  input_encoder_if bus ();

  input_encoder #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int         cyc;             // non-reset rising edges seen so far
  logic       dly1 [3];
  logic       dly2 [3];
  logic       win  [3][DB];    // last DB synchronized samples per channel
  logic       stable [3];
  logic [1:0] m_held;
  logic       m_pause;
  logic       m_mv;
  logic [1:0] m_cmd;
  bit         m_locked, m_chord, m_active;
  logic       m_key;
  int         m_age;           // edges since the press that started HOLD
  int         log_cyc [$];
  logic [1:0] log_code [$];

  function automatic void model_reset();
    for (int ch = 0; ch < 3; ch++) begin
      dly1[ch] = REST[ch];
      dly2[ch] = REST[ch];
      stable[ch] = REST[ch];
      for (int k = 0; k < DB; k++) win[ch][k] = REST[ch];
    end
    m_held = 2'b00; m_pause = 1'b0; m_mv = 1'b0; m_cmd = 2'b00;
    m_locked = 0; m_chord = 0; m_active = 0; m_key = 1'b0; m_age = 0;
  endfunction

  // Command rules applied to the debounced levels valid before this edge.
  function automatic void cmd_step(input logic [1:0] h, input logic p);
    bit         want;
    logic [1:0] code;
    int         t;
    want = 0;
    code = m_cmd;
    if (p) begin
      m_locked = 1; m_chord = 0; m_active = 0;
    end else if (m_locked) begin
      if (h == 2'b00) m_locked = 0;
    end else if (m_chord) begin
      if (h == 2'b00) m_chord = 0;
    end else if (m_active) begin
      if (h == 2'b11) begin
        if (!m_mv) begin want = 1; code = 2'b11; m_active = 0; m_chord = 1; end
      end else if (!h[m_key]) begin
        m_active = 0;
      end else begin
        t = m_age + 1;
        if (t == RD || (t > RD && ((t - RD) % RR) == 0)) begin
          if (!m_mv) begin want = 1; code = m_key ? 2'b10 : 2'b01; m_age = t; end
        end else begin
          m_age = t;
        end
      end
    end else begin
      if (h == 2'b11) begin
        if (!m_mv) begin want = 1; code = 2'b11; m_chord = 1; end
      end else if (h != 2'b00) begin
        if (!m_mv) begin want = 1; code = h; m_active = 1; m_key = h[1]; m_age = 0; end
      end
    end
    m_mv = want;
    if (want) begin
      m_cmd = code;
      log_cyc.push_back(cyc);
      log_code.push_back(code);
    end
  endfunction

  function automatic void model_step(input logic [2:0] raw3);
    logic x;
    bit   all_diff;
    cmd_step(m_held, m_pause);
    for (int ch = 0; ch < 3; ch++) begin
      x = dly2[ch];
      dly2[ch] = dly1[ch];
      dly1[ch] = raw3[ch];
      for (int k = DB - 1; k > 0; k--) win[ch][k] = win[ch][k-1];
      win[ch][0] = x;
      all_diff = 1;
      for (int k = 0; k < DB; k++) if (win[ch][k] == stable[ch]) all_diff = 0;
      if (all_diff) stable[ch] = ~stable[ch];
    end
    m_held  = {~stable[1], ~stable[0]};
    m_pause = stable[2];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      cyc++;
      model_step({bus.switch_raw, bus.button_raw});
    end
  end

  // ---------------- per-cycle compare ----------------
  logic prev_mv = 1'b0;
  always @(negedge clk) begin
    check("move_valid", bus.move_valid, m_mv);
    check("move_cmd", bus.move_cmd, m_cmd);
    check("held", bus.held, m_held);
    check("pause", bus.pause, m_pause);
    if (bus.move_valid) begin
      $display("cycle %0d: move_cmd=%b", cyc, bus.move_cmd);
      check("no_back_to_back", prev_mv, 0);
    end
    prev_mv = bus.move_valid;
  end

  // ---------------- directed helpers ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_pulse(input string name, input int idx, input int base,
                             input int rel, input logic [1:0] code);
    int act_rel;
    int act_code;
    act_rel  = (idx < log_cyc.size()) ? log_cyc[idx] - base : -1;
    act_code = (idx < log_cyc.size()) ? int'(log_code[idx]) : -1;
    check({name, "_cycle"}, act_rel, rel);
    check({name, "_code"}, act_code, code);
  endtask

  task automatic settle();
    bus.button_raw = 2'b11;
    bus.switch_raw = 1'b0;
    wait_cycles(20);
    log_cyc.delete();
    log_code.delete();
  endtask

  int base;
  int base2;

  initial begin
    bus.button_raw = 2'b11;
    bus.switch_raw = 1'b0;
    cyc = 0;
    wait_cycles(3);
    // Reset state, literal
    check("rst_move_valid", bus.move_valid, 0);
    check("rst_move_cmd", bus.move_cmd, 0);
    check("rst_held", bus.held, 0);
    check("rst_pause", bus.pause, 0);
    rst_n = 1'b1;
    settle();

    // Single down press: one pulse 7 edges after the raw edge
    base = cyc;
    bus.button_raw = 2'b10;
    wait_cycles(5);
    check("press_held_early", bus.held, 2'b00);
    wait_cycles(1);
    check("press_held", bus.held, 2'b01);
    wait_cycles(2);
    bus.button_raw = 2'b11;
    wait_cycles(20);
    check("press_count", log_cyc.size(), 1);
    check_pulse("press", 0, base, 7, 2'b01);
    settle();

    // 3-cycle glitch is ignored
    bus.button_raw = 2'b10;
    wait_cycles(3);
    bus.button_raw = 2'b11;
    for (int i = 0; i < 15; i++) begin
      wait_cycles(1);
      check("glitch_held", bus.held, 2'b00);
    end
    check("glitch_count", log_cyc.size(), 0);
    settle();

    // Up key held 40 cycles: press, delay, then periodic repeats; the pulse at
    // 42 still happens because release takes 7 edges to reach the FSM.
    base = cyc;
    bus.button_raw = 2'b01;
    wait_cycles(40);
    bus.button_raw = 2'b11;
    wait_cycles(20);
    check("repeat_count", log_cyc.size(), 7);
    check_pulse("repeat0", 0, base, 7, 2'b10);
    check_pulse("repeat1", 1, base, 17, 2'b10);
    check_pulse("repeat2", 2, base, 22, 2'b10);
    check_pulse("repeat3", 3, base, 27, 2'b10);
    check_pulse("repeat5", 5, base, 37, 2'b10);
    check_pulse("repeat6", 6, base, 42, 2'b10);
    settle();

    // Staggered chord: one down pulse, one fire, then silence
    base = cyc;
    bus.button_raw = 2'b10;
    wait_cycles(5);
    bus.button_raw = 2'b00;
    wait_cycles(30);
    bus.button_raw = 2'b11;
    wait_cycles(20);
    check("chord_count", log_cyc.size(), 2);
    check_pulse("chord_down", 0, base, 7, 2'b01);
    check_pulse("chord_fire", 1, base, 12, 2'b11);
    settle();

    // Pause while held, unpause still held: no moves until release + re-press
    base = cyc;
    bus.button_raw = 2'b10;
    wait_cycles(9);
    bus.switch_raw = 1'b1;
    wait_cycles(5);
    check("pause_early", bus.pause, 0);
    wait_cycles(2);
    check("pause_set", bus.pause, 1);
    wait_cycles(13);
    bus.switch_raw = 1'b0;
    wait_cycles(20);
    check("pause_clear", bus.pause, 0);
    bus.button_raw = 2'b11;
    wait_cycles(15);
    base2 = cyc;
    bus.button_raw = 2'b10;
    wait_cycles(10);
    bus.button_raw = 2'b11;
    wait_cycles(20);
    check("pause_count", log_cyc.size(), 2);
    check_pulse("pause_first", 0, base, 7, 2'b01);
    check_pulse("pause_repress", 1, base2, 7, 2'b01);
    settle();

    // Reset mid-press: outputs drop at once, fresh debounce after release
    bus.button_raw = 2'b10;
    wait_cycles(5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_move_valid", bus.move_valid, 0);
    check("midrst_held", bus.held, 0);
    wait_cycles(3);
    rst_n = 1'b1;
    base = cyc;
    wait_cycles(10);
    bus.button_raw = 2'b11;
    wait_cycles(20);
    check("midrst_count", log_cyc.size(), 1);
    check_pulse("midrst", 0, base, 7, 2'b01);
    settle();

    // Randomized key/switch activity with occasional resets
    for (int seg = 0; seg < 160; seg++) begin
      int act;
      act = $urandom_range(0, 39);
      if (act == 0) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        wait_cycles($urandom_range(1, 3));
        rst_n = 1'b1;
      end else if (act < 5) begin
        bus.switch_raw = ~bus.switch_raw;
      end else begin
        bus.button_raw = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 3) == 0) wait_cycles($urandom_range(1, 4));
      else wait_cycles($urandom_range(5, 30));
    end
    settle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
